// File: rtl/lcd_frame_feeder.sv
// Double-buffered LCD frame store: the drawing side writes or clears the back bank while the
// LCD controller streams the front bank. Banks swap only at a frame wrap.
module lcd_frame_feeder #(
    parameter int PAGES = 8,
    parameter int COLS  = 64,
    parameter int DW    = 8,
    parameter int AW    = $clog2(PAGES * COLS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en_tran,
    output logic [DW-1:0] data,
    output logic          data_valid,
    output logic          frame_done,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          clear_req,
    input  logic          swap_req,
    output logic          busy,
    output logic          front_bank
);

    localparam int            DEPTH = PAGES * COLS;
    localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t        state, state_next;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] clr_ptr;
    logic          swap_pending;

    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;

    // Bank select is the MSB of the RAM address.
    logic [DW-1:0] mem [0:2*DEPTH-1];

    logic wrap;
    logic swap_now;

    assign wrap     = en_tran && (rd_ptr == LAST);
    assign swap_now = wrap && (swap_pending || swap_req) && !busy;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (clear_req) state_next = CLEAR;
            CLEAR:   if (clr_ptr == LAST) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        busy      = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = wr_addr;
        mem_wdata = wr_data;
        case (state)
            IDLE: mem_we = wr_en;
            CLEAR: begin
                busy      = 1'b1;
                mem_we    = 1'b1;
                mem_waddr = clr_ptr;
                mem_wdata = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                clr_ptr <= '0;
        else if (state == IDLE) clr_ptr <= '0;
        else                    clr_ptr <= clr_ptr + 1'b1;
    end

    // NOTE: the frame store has no reset; only the control registers around it do.
    always_ff @(posedge clk) begin
        if (mem_we) mem[{~front_bank, mem_waddr}] <= mem_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data       <= '0;
            data_valid <= 1'b0;
            frame_done <= 1'b0;
            rd_ptr     <= '0;
        end else begin
            data_valid <= en_tran;
            frame_done <= wrap;
            if (en_tran) begin
                data   <= mem[{front_bank, rd_ptr}];
                rd_ptr <= wrap ? '0 : rd_ptr + 1'b1;
            end
        end
    end

    // A clear in progress owns the back bank, so a wrap while busy leaves the swap pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            front_bank   <= 1'b0;
            swap_pending <= 1'b0;
        end else if (swap_now) begin
            front_bank   <= ~front_bank;
            swap_pending <= 1'b0;
        end else if (swap_req) begin
            swap_pending <= 1'b1;
        end
    end

endmodule
